// File: rtl/jedro_1_defines.sv
// Shared definitions for the jedro_1 core: data/register widths and the
// load-store unit's control encoding, FSM states and lane helpers.
package jedro_1_defines;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int LSU_CTRL_WIDTH = 4;

    // Access size field of the LSU control word.
    localparam logic [1:0] LSU_SIZE_BYTE = 2'b00;
    localparam logic [1:0] LSU_SIZE_HALF = 2'b01;
    localparam logic [1:0] LSU_SIZE_WORD = 2'b10;
    localparam logic [1:0] LSU_SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT_RVALID
    } lsu_state_t;

    // Field view of lsu_ctrl_i: [3]=we, [2]=unsigned load, [1:0]=size.
    typedef struct packed {
        logic       we;
        logic       is_unsigned;
        logic [1:0] size;
    } lsu_ctrl_t;

    // Byte enables for an access of the given size at a lane offset.
    function automatic logic [3:0] lsu_byte_en(input logic [1:0] size,
                                               input logic [1:0] off);
        case (size)
            LSU_SIZE_BYTE: return 4'b0001 << off;
            LSU_SIZE_HALF: return 4'b0011 << off;
            default:       return 4'b1111;
        endcase
    endfunction

    // Replicate right-aligned store data into every lane it could land in,
    // so the byte enables alone select the written bytes.
    function automatic logic [DATA_WIDTH-1:0] lsu_store_data(
        input logic [1:0]            size,
        input logic [DATA_WIDTH-1:0] wdata
    );
        case (size)
            LSU_SIZE_BYTE: return {4{wdata[7:0]}};
            LSU_SIZE_HALF: return {2{wdata[15:0]}};
            default:       return wdata;
        endcase
    endfunction

endpackage

// File: rtl/jedro_1_lsu_rdata_ext.sv
// Load data extraction for jedro_1_lsu: selects the addressed lane of a raw
// memory word and sign- or zero-extends byte/half results. Purely combinational.
module jedro_1_lsu_rdata_ext #(
    parameter int DATA_WIDTH = jedro_1_defines::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] raw_i,
    input  logic [1:0]            off_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    output logic [DATA_WIDTH-1:0] ext_o
);
    import jedro_1_defines::*;

    // Only the low half of the shifted word can ever be a byte/half result.
    logic [15:0] lane;
    logic        sign_b;
    logic        sign_h;

    assign lane   = 16'(raw_i >> {off_i, 3'b000});
    assign sign_b = !unsigned_i && lane[7];
    assign sign_h = !unsigned_i && lane[15];

    // Extend the selected lane according to access size; words pass through.
    always_comb begin
        case (size_i)
            LSU_SIZE_BYTE: ext_o = {{(DATA_WIDTH-8){sign_b}}, lane[7:0]};
            LSU_SIZE_HALF: ext_o = {{(DATA_WIDTH-16){sign_h}}, lane[15:0]};
            default:       ext_o = raw_i;
        endcase
    end

endmodule

// File: rtl/jedro_1_lsu.sv
// jedro_1 load-store unit. Accepts one memory instruction at a time, runs a
// req/gnt/rvalid transaction on the data port, aligns store data and hands
// extended load results to register writeback.
// Build option: define JEDRO_1_LSU_MISALIGN_CHECK_EN to detect and reject
// misaligned accesses; without it offsets are forced aligned and size 11 is
// treated as a word.
module jedro_1_lsu #(
    parameter int DATA_WIDTH     = jedro_1_defines::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = jedro_1_defines::REG_ADDR_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,

    input  logic                      lsu_valid_i,
    input  logic [3:0]                lsu_ctrl_i,
    input  logic [DATA_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [REG_ADDR_WIDTH-1:0] reg_dest_addr_i,
    output logic                      stall_o,

    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic [REG_ADDR_WIDTH-1:0] reg_dest_addr_o,
    output logic                      reg_wb_o,
    output logic                      misaligned_o,

    output logic                      data_req_o,
    input  logic                      data_gnt_i,
    output logic [DATA_WIDTH-1:0]     data_addr_o,
    output logic                      data_we_o,
    output logic [3:0]                data_be_o,
    output logic [DATA_WIDTH-1:0]     data_wdata_o,
    input  logic                      data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     data_rdata_i
);
    import jedro_1_defines::*;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    lsu_ctrl_t  req_ctrl;
    logic [1:0] req_size;
    logic [1:0] req_off;
    logic       req_ok;
`ifdef JEDRO_1_LSU_MISALIGN_CHECK_EN
    logic       req_misaligned;
`endif

    // Decode the incoming request into an effective size/offset and decide
    // whether it may be issued.
    always_comb begin
        req_ctrl = lsu_ctrl_t'(lsu_ctrl_i);
        req_size = req_ctrl.size;
        req_off  = addr_i[1:0];
`ifdef JEDRO_1_LSU_MISALIGN_CHECK_EN
        req_misaligned = (req_size == LSU_SIZE_ILL)
                      || ((req_size == LSU_SIZE_HALF) && req_off[0])
                      || ((req_size == LSU_SIZE_WORD) && (req_off != 2'b00));
        req_ok = !req_misaligned;
`else
        // Without the check, drop the low offset bits the size cannot use.
        if (req_size == LSU_SIZE_HALF) begin
            req_off = {addr_i[1], 1'b0};
        end else if (req_size != LSU_SIZE_BYTE) begin
            req_off  = 2'b00;
            req_size = LSU_SIZE_WORD;
        end
        req_ok = 1'b1;
`endif
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    lsu_state_t                state_q, state_d;
    logic                      data_req_q, data_req_d;
    logic [DATA_WIDTH-1:0]     data_addr_q, data_addr_d;
    logic                      data_we_q, data_we_d;
    logic [3:0]                data_be_q, data_be_d;
    logic [DATA_WIDTH-1:0]     data_wdata_q, data_wdata_d;
    logic [1:0]                size_q, size_d;
    logic                      uns_q, uns_d;
    logic [1:0]                off_q, off_d;
    logic [REG_ADDR_WIDTH-1:0] reg_dest_q, reg_dest_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic                      reg_wb_q, reg_wb_d;
`ifdef JEDRO_1_LSU_MISALIGN_CHECK_EN
    logic                      misaligned_q, misaligned_d;
`endif

    logic [DATA_WIDTH-1:0]     load_ext;

    jedro_1_lsu_rdata_ext #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rdata_ext (
        .raw_i      (data_rdata_i),
        .off_i      (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .ext_o      (load_ext)
    );

    // Next-state and next-output logic of the transaction FSM.
    always_comb begin
        // NOTE: every _d starts at its flop value (pulses at 0) so no path
        // through the case statement can infer a latch.
        state_d      = state_q;
        data_req_d   = data_req_q;
        data_addr_d  = data_addr_q;
        data_we_d    = data_we_q;
        data_be_d    = data_be_q;
        data_wdata_d = data_wdata_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        reg_dest_d   = reg_dest_q;
        rdata_d      = rdata_q;
        reg_wb_d     = 1'b0;
`ifdef JEDRO_1_LSU_MISALIGN_CHECK_EN
        misaligned_d = 1'b0;
`endif

        case (state_q)
            LSU_IDLE: begin
                if (lsu_valid_i && req_ok) begin
                    state_d      = LSU_REQ;
                    data_req_d   = 1'b1;
                    data_addr_d  = {addr_i[DATA_WIDTH-1:2], 2'b00};
                    data_we_d    = req_ctrl.we;
                    data_be_d    = lsu_byte_en(req_size, req_off);
                    data_wdata_d = lsu_store_data(req_size, wdata_i);
                    size_d       = req_size;
                    uns_d        = req_ctrl.is_unsigned;
                    off_d        = req_off;
                    reg_dest_d   = reg_dest_addr_i;
                end
`ifdef JEDRO_1_LSU_MISALIGN_CHECK_EN
                misaligned_d = lsu_valid_i && !req_ok;
`endif
            end

            LSU_REQ: begin
                // Address and data stay put until memory grants.
                if (data_gnt_i) begin
                    data_req_d = 1'b0;
                    state_d    = data_we_q ? LSU_IDLE : LSU_WAIT_RVALID;
                end
            end

            LSU_WAIT_RVALID: begin
                if (data_rvalid_i) begin
                    rdata_d  = load_ext;
                    reg_wb_d = 1'b1;
                    state_d  = LSU_IDLE;
                end
            end

            default: begin
                state_d    = LSU_IDLE;
                data_req_d = 1'b0;
            end
        endcase
    end

    // Transaction FSM register bank with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge
        // values regardless of statement order.
        if (!rstn_i) begin
            state_q      <= LSU_IDLE;
            data_req_q   <= 1'b0;
            data_addr_q  <= '0;
            data_we_q    <= 1'b0;
            data_be_q    <= '0;
            data_wdata_q <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            off_q        <= '0;
            reg_dest_q   <= '0;
            rdata_q      <= '0;
            reg_wb_q     <= 1'b0;
`ifdef JEDRO_1_LSU_MISALIGN_CHECK_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            data_req_q   <= data_req_d;
            data_addr_q  <= data_addr_d;
            data_we_q    <= data_we_d;
            data_be_q    <= data_be_d;
            data_wdata_q <= data_wdata_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            reg_dest_q   <= reg_dest_d;
            rdata_q      <= rdata_d;
            reg_wb_q     <= reg_wb_d;
`ifdef JEDRO_1_LSU_MISALIGN_CHECK_EN
            misaligned_q <= misaligned_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Stall while busy, and in the accept cycle of any request that will be
    // issued; held low during reset so the pipeline is released at once.
    assign stall_o = rstn_i && ((state_q != LSU_IDLE) || (lsu_valid_i && req_ok));

    assign data_req_o      = data_req_q;
    assign data_addr_o     = data_addr_q;
    assign data_we_o       = data_we_q;
    assign data_be_o       = data_be_q;
    assign data_wdata_o    = data_wdata_q;
    assign rdata_o         = rdata_q;
    assign reg_dest_addr_o = reg_dest_q;
    assign reg_wb_o        = reg_wb_q;
`ifdef JEDRO_1_LSU_MISALIGN_CHECK_EN
    assign misaligned_o    = misaligned_q;
`else
    assign misaligned_o    = 1'b0;
`endif

endmodule
